// File: rtl/axis_downsizer.sv
// Wide-to-narrow AXI-Stream converter: holds one wide beat and replays its kept lanes,
// lowest lane first, one narrow beat per cycle.
module axis_downsizer #(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    zero_keep_o
);

  localparam int unsigned IdxW = $clog2(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0] hold_data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_mask_q, rem_mask_d;
  logic                    hold_last_q;
  logic                    zero_keep_q;

  logic            full;
  logic            one_left;
  logic [IdxW-1:0] idx;
  logic            m_xfer;
  logic            last_xfer;
  logic            s_xfer;
  logic            load;

  // Lowest remaining lane wins; scanning downward leaves the smallest index in idx.
  always_comb begin
    idx = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) idx = IdxW'(unsigned'(i));
    end
  end

  assign full      = |rem_mask_q;
  assign one_left  = full && ((rem_mask_q & (rem_mask_q - 1'b1)) == '0);
  assign m_valid_o = full;
  assign m_data_o  = full ? hold_data_q[idx] : '0;
  assign m_last_o  = full & hold_last_q & one_left;

  assign m_xfer    = m_valid_o & m_ready_i;
  assign last_xfer = m_xfer & one_left;
  assign s_ready_o = ~full | last_xfer;
  assign s_xfer    = s_valid_i & s_ready_o;
  assign load      = s_xfer & (|s_keep_i);

  always_comb begin
    rem_mask_d = rem_mask_q;
    if (m_xfer) rem_mask_d[idx] = 1'b0;
    // A new beat overrides the clear of the final lane, giving back-to-back operation.
    if (load) rem_mask_d = s_keep_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_mask_q  <= '0;
      hold_last_q <= 1'b0;
      zero_keep_q <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) hold_data_q[i] <= '0;
    end else begin
      rem_mask_q <= rem_mask_d;
      if (load) begin
        hold_last_q <= s_last_i;
        for (int i = 0; i < T_DATA_RATIO; i++) hold_data_q[i] <= s_data_i[i];
      end
      // Empty-keep beats are dropped along with their last flag; remember that it happened.
      if (s_xfer && (s_keep_i == '0)) zero_keep_q <= 1'b1;
    end
  end

  assign zero_keep_o = zero_keep_q;

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer: table of single wide beats plus hand-written
// back-to-back, backpressure, zero-keep and reset sequences.
module tb_axis_downsizer;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data [3:0];
  logic [3:0] s_keep;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       zero_keep;

  int n_vec = 0;
  int n_err = 0;

  axis_downsizer #(
    .T_DATA_WIDTH(8),
    .T_DATA_RATIO(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (s_data),
    .s_keep_i   (s_keep),
    .s_last_i   (s_last),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .zero_keep_o(zero_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // lanes: lane i at [8i+:8]; exp: k-th narrow beat at [8k+:8]
  typedef struct {
    logic [31:0] lanes;
    logic [3:0]  keep;
    logic        last;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] lanes, input logic [3:0] keep, input logic last);
    for (int i = 0; i < 4; i++) s_data[i] = lanes[8*i+:8];
    s_keep  = keep;
    s_last  = last;
    s_valid = 1'b1;
  endtask

  // Loads one beat into an empty DUT with m_ready=1 and checks every narrow beat it emits.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    m_ready = 1'b1;
    drive_beat(v.lanes, v.keep, v.last);
    #1 check({tag, " s_ready idle"}, 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      #1;
      check($sformatf("%s valid[%0d]", tag, k), 32'(m_valid), 32'd1);
      check($sformatf("%s data[%0d]", tag, k), 32'(m_data), 32'(v.exp[8*k+:8]));
      check($sformatf("%s last[%0d]", tag, k), 32'(m_last), 32'(v.last && (k == v.n - 1)));
      check($sformatf("%s s_ready[%0d]", tag, k), 32'(s_ready), 32'(k == v.n - 1));
      @(negedge clk);
    end
    #1 check({tag, " drained"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_exp [2];
    logic [6:0]  rdy_seq;
    int          ptr;

    vecs[0] = '{lanes: 32'h44332211, keep: 4'hF, last: 1'b1, n: 4, exp: 32'h44332211};
    vecs[1] = '{lanes: 32'h0D0C0B0A, keep: 4'hA, last: 1'b1, n: 2, exp: 32'h00000D0B};
    vecs[2] = '{lanes: 32'h87654321, keep: 4'h5, last: 1'b0, n: 2, exp: 32'h00006521};
    vecs[3] = '{lanes: 32'hA1B2C3D4, keep: 4'h8, last: 1'b1, n: 1, exp: 32'h000000A1};
    vecs[4] = '{lanes: 32'h0F1E2D3C, keep: 4'h6, last: 1'b1, n: 2, exp: 32'h00001E2D};
    vecs[5] = '{lanes: 32'h00000099, keep: 4'h1, last: 1'b0, n: 1, exp: 32'h00000099};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) s_data[i] = '0;
    #12;
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data", 32'(m_data), 32'd0);
    check("rst m_last", 32'(m_last), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd1);
    check("rst zero_keep", 32'(zero_keep), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) apply(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back: second beat waits on s_valid and is taken in the 0x44 cycle.
    b2b_exp[0] = 32'h44332211;
    b2b_exp[1] = 32'h88776655;
    @(negedge clk);
    drive_beat(b2b_exp[0], 4'hF, 1'b1);
    @(negedge clk);
    drive_beat(b2b_exp[1], 4'hF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) s_valid = 1'b0;
      #1;
      check($sformatf("b2b valid[%0d]", k), 32'(m_valid), 32'd1);
      check($sformatf("b2b data[%0d]", k), 32'(m_data), 32'(b2b_exp[k/4][8*(k%4)+:8]));
      check($sformatf("b2b last[%0d]", k), 32'(m_last), 32'((k % 4) == 3));
      check($sformatf("b2b s_ready[%0d]", k), 32'(s_ready), 32'((k % 4) == 3));
      @(negedge clk);
    end
    #1 check("b2b drained", 32'(m_valid), 32'd0);

    // Backpressure: m_ready 1,0,0,1,1,0,1 must yield exactly four ordered transfers.
    rdy_seq = 7'b1011001;  // bit c = m_ready in cycle c
    @(negedge clk);
    drive_beat(32'h44332211, 4'hF, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    ptr = 0;
    for (int c = 0; c < 7; c++) begin
      m_ready = rdy_seq[c];
      #1;
      check($sformatf("bp valid[%0d]", c), 32'(m_valid), 32'd1);
      check($sformatf("bp data[%0d]", c), 32'(m_data), 32'(8'h11 * (ptr + 1)));
      check($sformatf("bp last[%0d]", c), 32'(m_last), 32'(ptr == 3));
      if (rdy_seq[c]) ptr++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1 check("bp drained", 32'(m_valid), 32'd0);

    // Zero keep: accepted, nothing emitted, sticky flag survives later traffic.
    @(negedge clk);
    drive_beat(32'hDEADBEEF, 4'h0, 1'b1);
    #1;
    check("zk s_ready", 32'(s_ready), 32'd1);
    check("zk flag before", 32'(zero_keep), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("zk no valid", 32'(m_valid), 32'd0);
    check("zk flag set", 32'(zero_keep), 32'd1);
    apply(vecs[0], "zk traffic");
    check("zk flag sticky", 32'(zero_keep), 32'd1);

    // Reset after the second narrow beat discards the held lanes.
    @(negedge clk);
    drive_beat(32'h44332211, 4'hF, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #1 check("rm lane0", 32'(m_data), 32'h11);
    @(negedge clk);
    #1 check("rm lane1", 32'(m_data), 32'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm m_valid", 32'(m_valid), 32'd0);
    check("rm m_data", 32'(m_data), 32'd0);
    check("rm zero_keep", 32'(zero_keep), 32'd0);
    check("rm s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rm no partial", 32'(m_valid), 32'd0);
    apply(vecs[2], "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- Wide-to-narrow AXI-Stream width converter; the companion to the team's narrow-to-wide upsizer.
- Accepts one beat of T_DATA_RATIO lanes, each T_DATA_WIDTH bits, and replays the kept lanes one per cycle on a narrow master port, lane 0 first.
- Sits between the wide datapath and narrow sinks; also used in loopback benches against the upsizer.

Parameters:
- T_DATA_WIDTH, 4, width in bits of one narrow beat / one wide lane.
- T_DATA_RATIO, 4, lanes per wide beat; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  [T_DATA_WIDTH-1:0] x [T_DATA_RATIO-1:0]  wide beat, unpacked lane array; lane i = s_data_i[i].
- s_keep_i  in  T_DATA_RATIO  lane qualifiers; bit i qualifies lane i.
- s_last_i  in  1  wide beat ends a packet.
- s_valid_i  in  1  wide beat valid.
- s_ready_o  out  1  wide beat accepted when s_valid_i & s_ready_o.
- m_data_o  out  T_DATA_WIDTH  narrow beat.
- m_last_o  out  1  final narrow beat of the packet.
- m_valid_o  out  1  narrow beat valid.
- m_ready_i  in  1  narrow sink ready.
- zero_keep_o  out  1  sticky flag: a beat with all-zero s_keep_i was consumed.

Behaviour:
- State registers:
  - hold_data: wide lanes.
  - rem_mask: T_DATA_RATIO bits, lanes still to send.
  - hold_last: 1 bit.
  - full = |rem_mask.
- Reset (async, rst_n=0): rem_mask=0, hold_last=0, hold_data=0, zero_keep_o=0. Hence m_valid_o=0, m_last_o=0, m_data_o=0 while in reset. Reset mid-packet discards all held lanes; there is no partial output after release.
- Output selection:
  - idx = lowest set bit of rem_mask.
  - m_data_o = hold_data[idx] when full, else 0.
  - m_valid_o = full.
  - m_last_o = full & hold_last & (rem_mask has exactly one bit set).
- Outputs depend only on registers; there is no combinational path from s_* to m_*.
- Narrow handshake: on m_valid_o & m_ready_i, clear rem_mask[idx]. While m_ready_i=0, m_data_o, m_last_o and m_valid_o hold stable (AXI rule).
- last_xfer = m_valid_o & m_ready_i & (rem_mask has one bit set).
- s_ready_o = ~full | last_xfer. This is combinational from m_ready_i and registers. It must not depend on s_valid_i.
- Load, on s_valid_i & s_ready_o with s_keep_i != 0: hold_data <= s_data_i, rem_mask <= s_keep_i, hold_last <= s_last_i.
  - Load has priority over the clear of the final lane in the same cycle. This gives back-to-back operation with no bubble.
- Zero-keep beat (s_keep_i == 0) accepted:
  - The beat is discarded and the registers are not loaded. If it coincides with last_xfer, rem_mask goes to 0.
  - zero_keep_o <= 1, sticky until reset.
  - Its s_last_i is dropped, so the packet boundary is lost. This is why the flag exists.
- Sparse keep: lanes with keep=0 are skipped without a cycle penalty. E.g. keep=4'b1010 emits lane1 then lane3 (2 cycles).
- Latency and throughput:
  - Wide beat accepted at edge N; its first narrow beat is valid in cycle N+1.
  - Sustained rate is 1 narrow beat/cycle with m_ready_i=1 and s_valid_i=1.
  - A full-keep wide beat occupies T_DATA_RATIO cycles.
- Backpressure: s_ready_o stays 0 while full, except in the final-lane transfer cycle.
- m_last_o is never asserted on a non-final lane. A beat with s_last_i=0 never produces m_last_o=1.
- Width rule: idx is a $clog2(T_DATA_RATIO)-bit priority encode; there is no arithmetic wrap.
- Target size is 150-250 lines of RTL.

Test Plan:
- T_DATA_WIDTH=8, T_DATA_RATIO=4.
- Full beat: lanes {0x44,0x33,0x22,0x11} (lane3..0), keep=4'hF, last=1, m_ready=1 -> m_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles. m_last=1 only with 0x44. s_ready_o=0 for cycles 2-4 and 1 in the 0x44 cycle.
- Back-to-back: two full beats with s_valid held 1 -> 8 contiguous narrow beats, no m_valid gap. Second beat accepted in the same cycle 0x44 transfers.
- Sparse keep: keep=4'b1010, lanes {0xD,0xC,0xB,0xA}, last=1 -> 0xB then 0xD with m_last=1. Total 2 cycles, then s_ready_o=1.
- Backpressure: full beat with m_ready toggling 1,0,0,1,1,0,1 -> exactly 4 transfers in order 0x11..0x44. m_data_o is stable during every m_ready=0 cycle, and no lane is duplicated or lost.
- Zero keep: keep=0, last=1, accepted while empty -> no m_valid. zero_keep_o goes 1 next cycle and stays 1 through later traffic until rst_n=0.
- Reset mid-beat: assert rst_n=0 asynchronously after the 2nd narrow beat -> m_valid_o=0 immediately. After release, s_ready_o=1 and the next beat emits from its lane 0.
